// File: rtl/mcycle_control_pkg.sv
// ---------------------------------------------------------------------------
// mcycle_control_pkg
//
// Shared definitions for the multi-cycle control unit:
//   - opcode encodings (instruction bits [15:12])
//   - R-type function codes (instruction bits [5:0])
//   - FSM state encoding
//   - PC source select encoding
//   - ctrl_t: the full bundle of control strobes driven by the FSM
// ---------------------------------------------------------------------------
package mcycle_control_pkg;

    // Opcodes
    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    // R-type function codes. ALU operations occupy 0..FN_SHR contiguously.
    localparam logic [5:0] FN_SHR   = 6'd7;
    localparam logic [5:0] FN_JPR   = 6'd25;
    localparam logic [5:0] FN_JRL   = 6'd26;
    localparam logic [5:0] FN_WWD   = 6'd28;
    localparam logic [5:0] FN_HLT   = 6'd29;

    // FSM states
    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    // PC source select
    typedef enum logic [1:0] {
        PC_SRC_NEXT   = 2'd0,   // PC + 1
        PC_SRC_BRANCH = 2'd1,   // branch target
        PC_SRC_JUMP   = 2'd2,   // jump target
        PC_SRC_REG    = 2'd3    // register (JPR / JRL)
    } pc_src_e;

    // Every control output except the instruction counter
    typedef struct packed {
        logic       read_m;
        logic       write_m;
        logic       i_or_d;
        logic       ir_write;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       pc_write;
        logic       pc_write_cond;
        pc_src_e    pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       wwd_enable;
        logic       is_halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/inst_decoder.sv
// ---------------------------------------------------------------------------
// inst_decoder
//
// Purely combinational classification of the instruction held in the
// instruction register.
//
// Ports
//   opcode           in  [3:0]  instruction bits [15:12]
//   func_code        in  [5:0]  instruction bits [5:0]
//   is_branch        out        BNE / BEQ / BGZ / BLZ
//   is_mem           out        LWD / SWD
//   is_load          out        LWD
//   is_jump          out        JMP / JAL / JPR / JRL
//   is_rtype_nowrite out        R-type that completes without a register write
//                               (WWD / JPR / HLT)
//   is_halt          out        HLT
//   is_wwd           out        WWD
//   uses_imm         out        ALU second operand is the sign-extended immediate
//   is_defined       out        opcode / function code is a legal instruction
// ---------------------------------------------------------------------------
module inst_decoder
    import mcycle_control_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [5:0] func_code,
    output logic       is_branch,
    output logic       is_mem,
    output logic       is_load,
    output logic       is_jump,
    output logic       is_rtype_nowrite,
    output logic       is_halt,
    output logic       is_wwd,
    output logic       uses_imm,
    output logic       is_defined
);

    always_comb begin
        is_branch        = 1'b0;
        is_mem           = 1'b0;
        is_load          = 1'b0;
        is_jump          = 1'b0;
        is_rtype_nowrite = 1'b0;
        is_halt          = 1'b0;
        is_wwd           = 1'b0;
        uses_imm         = 1'b0;
        is_defined       = 1'b0;

        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
                is_branch  = 1'b1;
                is_defined = 1'b1;
            end
            OP_ADI, OP_ORI, OP_LHI: begin
                uses_imm   = 1'b1;
                is_defined = 1'b1;
            end
            OP_LWD: begin
                is_mem     = 1'b1;
                is_load    = 1'b1;
                uses_imm   = 1'b1;
                is_defined = 1'b1;
            end
            OP_SWD: begin
                is_mem     = 1'b1;
                uses_imm   = 1'b1;
                is_defined = 1'b1;
            end
            OP_JMP, OP_JAL: begin
                is_jump    = 1'b1;
                is_defined = 1'b1;
            end
            OP_RTYPE: begin
                if (func_code <= FN_SHR) begin
                    is_defined = 1'b1;
                end else begin
                    case (func_code)
                        FN_JPR: begin
                            is_jump          = 1'b1;
                            is_rtype_nowrite = 1'b1;
                            is_defined       = 1'b1;
                        end
                        FN_JRL: begin
                            is_jump    = 1'b1;
                            is_defined = 1'b1;
                        end
                        FN_WWD: begin
                            is_wwd           = 1'b1;
                            is_rtype_nowrite = 1'b1;
                            is_defined       = 1'b1;
                        end
                        FN_HLT: begin
                            is_halt          = 1'b1;
                            is_rtype_nowrite = 1'b1;
                            is_defined       = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mcycle_control.sv
// ---------------------------------------------------------------------------
// mcycle_control
//
// Multi-cycle CPU control FSM: IF -> ID -> (EX -> (MEM) -> (WB)) -> IF,
// plus an absorbing HALT state. Outputs are a Moore decode of the state and
// the externally registered instruction (opcode / func_code); the only
// input_ready dependence is the handshake completion in IF and MEM.
//
// Ports
//   clk            in        clock, rising edge
//   reset_n        in        synchronous active-low reset
//   opcode         in  [3:0] instruction register bits [15:12]
//   func_code      in  [5:0] instruction register bits [5:0]
//   input_ready    in        memory access completes this cycle
//   read_m         out       memory read request
//   write_m        out       memory write request
//   i_or_d         out       memory address select (0 = PC, 1 = ALU result)
//   ir_write       out       instruction register load strobe
//   alu_op         out [3:0] opcode forwarded to ALU control (EX only)
//   alu_src        out       0 = register operand, 1 = immediate
//   pc_write       out       unconditional PC update
//   pc_write_cond  out       branch-conditional PC update
//   pc_src         out [1:0] PC source select
//   reg_write      out       register file write enable
//   mem_to_reg     out       register write data from memory
//   wwd_enable     out       one-cycle strobe latching the output port
//   is_halted      out       sticky halt indicator
//   num_inst       out [15:0] completed-instruction count (wraps)
// ---------------------------------------------------------------------------
module mcycle_control
    import mcycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic        input_ready,
    output logic        read_m,
    output logic        write_m,
    output logic        i_or_d,
    output logic        ir_write,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        wwd_enable,
    output logic        is_halted,
    output logic [15:0] num_inst
);

    state_e      state_reg;
    state_e      state_next;
    logic [15:0] num_inst_reg;
    logic        inst_done;
    ctrl_t       ctrl;
    ctrl_t       ctrl_out;

    logic is_branch;
    logic is_mem;
    logic is_load;
    logic is_jump;
    logic is_rtype_nowrite;
    logic is_halt;
    logic is_wwd;
    logic uses_imm;
    logic is_defined;

    inst_decoder u_inst_decoder (
        .opcode           (opcode),
        .func_code        (func_code),
        .is_branch        (is_branch),
        .is_mem           (is_mem),
        .is_load          (is_load),
        .is_jump          (is_jump),
        .is_rtype_nowrite (is_rtype_nowrite),
        .is_halt          (is_halt),
        .is_wwd           (is_wwd),
        .uses_imm         (uses_imm),
        .is_defined       (is_defined)
    );

    // -----------------------------------------------------------------------
    // State and instruction counter
    // -----------------------------------------------------------------------
    // An instruction completes whenever the FSM returns to IF from any other
    // state; HALT never returns to IF, so HLT is never counted.
    assign inst_done = (state_reg != ST_IF) && (state_next == ST_IF);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IF;
            num_inst_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (inst_done) begin
                num_inst_reg <= num_inst_reg + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and control decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ctrl       = CTRL_IDLE;

        case (state_reg)
            ST_IF: begin
                ctrl.read_m = 1'b1;
                if (input_ready) begin
                    ctrl.ir_write = 1'b1;
                    state_next    = ST_ID;
                end
            end

            ST_ID: begin
                if (is_halt) begin
                    state_next = ST_HALT;
                end else if (is_wwd) begin
                    ctrl.wwd_enable = 1'b1;
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_src     = PC_SRC_NEXT;
                    state_next      = ST_IF;
                end else if (is_jump) begin
                    // R-type jumps (JPR/JRL) take the target from a register.
                    // JAL and JRL link; JMP and JPR do not.
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_src    = (opcode == OP_RTYPE) ? PC_SRC_REG : PC_SRC_JUMP;
                    ctrl.reg_write = !is_rtype_nowrite && (opcode != OP_JMP);
                    state_next     = ST_IF;
                end else if (!is_defined) begin
                    // Illegal encodings retire as a no-op.
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_NEXT;
                    state_next    = ST_IF;
                end else begin
                    state_next = ST_EX;
                end
            end

            ST_EX: begin
                ctrl.alu_op  = opcode;
                ctrl.alu_src = uses_imm;
                if (is_branch) begin
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_src        = PC_SRC_BRANCH;
                    state_next         = ST_IF;
                end else if (is_mem) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end

            ST_MEM: begin
                // Request and address select are held steady until the
                // memory acknowledges.
                ctrl.i_or_d  = 1'b1;
                ctrl.read_m  = is_load;
                ctrl.write_m = !is_load;
                if (input_ready) begin
                    if (is_load) begin
                        state_next = ST_WB;
                    end else begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_NEXT;
                        state_next    = ST_IF;
                    end
                end
            end

            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = is_load;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_SRC_NEXT;
                state_next      = ST_IF;
            end

            ST_HALT: begin
                ctrl.is_halted = 1'b1;
            end

            default: begin
                state_next = ST_IF;
            end
        endcase
    end

    // While reset is held every control output is forced quiet, so an
    // interrupted memory access is dropped immediately.
    assign ctrl_out = reset_n ? ctrl : CTRL_IDLE;

    assign read_m        = ctrl_out.read_m;
    assign write_m       = ctrl_out.write_m;
    assign i_or_d        = ctrl_out.i_or_d;
    assign ir_write      = ctrl_out.ir_write;
    assign alu_op        = ctrl_out.alu_op;
    assign alu_src       = ctrl_out.alu_src;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign pc_src        = ctrl_out.pc_src;
    assign reg_write     = ctrl_out.reg_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign wwd_enable    = ctrl_out.wwd_enable;
    assign is_halted     = ctrl_out.is_halted;
    assign num_inst      = num_inst_reg;

endmodule

// File: doc/mcycle_control.md
MCYCLE_CONTROL -- requirements
Module: mcycle_control

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port opcode  input  4  instruction bits [15:12] from the instruction register.
REQ-004 SHALL have port func_code  input  6  instruction bits [5:0] from the instruction register.
REQ-005 SHALL have port input_ready  input  1  memory handshake: access complete this cycle.
REQ-006 SHALL have port read_m / write_m  output  1 each  memory read / write request.
REQ-007 SHALL have port i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-008 SHALL have port ir_write  output  1  instruction register load strobe.
REQ-009 SHALL have port alu_op  output  4  opcode forwarded to the ALU control stage, valid in EX.
REQ-010 SHALL have port alu_src  output  1  0 = register operand, 1 = sign-extended immediate.
REQ-011 SHALL have port pc_write / pc_write_cond  output  1 each  unconditional / branch-conditional PC update.
REQ-012 SHALL have port pc_src  output  2  0 = PC+1, 1 = branch target, 2 = jump target, 3 = register (JPR/JRL).
REQ-013 SHALL have port reg_write / mem_to_reg  output  1 each  register file write enable / write-data select.
REQ-014 SHALL have port wwd_enable  output  1  one-cycle strobe latching output_port.
REQ-015 SHALL have port is_halted  output  1  sticky halt indicator.
REQ-016 SHALL have port num_inst  output  16  count of completed instructions.

Function
REQ-017 SHALL implement states IF, ID, EX, MEM, WB, HALT; one state per cycle except IF/MEM, which wait on input_ready.
REQ-018 IF: read_m=1, i_or_d=0; on input_ready, ir_write=1 that cycle and go to ID; otherwise remain in IF.
REQ-019 ID: HLT (R-type, HLT func) -> HALT; WWD -> wwd_enable=1, pc_write=1, pc_src=0, go IF; JMP -> pc_write=1, pc_src=2, go IF; JAL -> reg_write=1, pc_write=1, pc_src=2, go IF; JPR -> pc_write=1, pc_src=3, go IF; JRL -> reg_write=1, pc_write=1, pc_src=3, go IF; all others -> EX.
REQ-020 EX: alu_op=opcode; alu_src=1 for ADI/ORI/LHI/LWD/SWD, else 0; BNE/BEQ/BGZ/BLZ -> pc_write_cond=1, pc_src=1, go IF; LWD/SWD -> MEM; other -> WB.
REQ-021 MEM: i_or_d=1; read_m=1 (LWD) or write_m=1 (SWD); wait for input_ready; LWD -> WB; SWD -> pc_write=1, pc_src=0, go IF.
REQ-022 WB: reg_write=1, mem_to_reg=1 only for LWD, pc_write=1, pc_src=0, go IF.
REQ-023 Undefined opcode or R-type func in ID SHALL be treated as a no-op: pc_write=1, pc_src=0, go IF.
REQ-024 All outputs not asserted by the current state SHALL be 0 (Moore-style decode of state plus registered instruction).
REQ-025 num_inst SHALL increment by 1 on every transition into IF from ID, EX, MEM or WB; it SHALL wrap 0xFFFF -> 0x0000.
REQ-026 HLT SHALL not increment num_inst; HALT is absorbing: is_halted=1, all strobes 0, until reset.
REQ-027 A read_m/write_m request SHALL remain asserted with stable i_or_d until input_ready is seen.

Reset
REQ-028 With reset_n=0 at a rising edge, state SHALL become IF and num_inst SHALL become 0; is_halted SHALL become 0; every other output SHALL be 0 during reset cycles.
REQ-029 Reset asserted mid-operation, including mid-MEM handshake or in HALT, SHALL abandon the access; read_m/write_m SHALL be 0 in the cycle after the edge.

Structure
REQ-030 Opcode, function-code, and pc_src encodings and state encodings SHALL reside in the shared opcode definitions file.
REQ-031 Instruction classification (is_branch, is_mem, is_jump, is_rtype_nowrite) SHALL be a combinational sub-module inst_decoder.

Verification
REQ-032 Reset then ADI with input_ready=1 each IF -> IF,ID,EX,WB,IF; alu_src=1 in EX; reg_write=1 in WB; num_inst=1.
REQ-033 LWD with input_ready delayed 3 cycles in MEM -> read_m=1, i_or_d=1 held 3 cycles; WB mem_to_reg=1; num_inst +1.
REQ-034 BEQ -> ID, EX with pc_write_cond=1, pc_src=1; no reg_write; next state IF.
REQ-035 WWD then HLT -> wwd_enable one-cycle pulse in ID; is_halted=1 stays set for 10+ cycles; num_inst increments only for WWD.
REQ-036 reset_n=0 during SWD MEM wait -> write_m=0 next cycle, state IF, num_inst=0.
REQ-037 Preload 0xFFFF completions -> next completed instruction gives num_inst=0x0000.
